// File: rtl/plic_arbiter.sv
// plic_arbiter
// Picks the highest-priority eligible interrupt source out of eight. It raises
// a request to the CPU and tracks the request through acknowledge, service and
// end-of-interrupt.
//
// Ports
//   pclk, preset_n   clock, asynchronous active-low reset
//   isr[7:0]         latched IRQ status, one bit per source
//   ier[7:0]         IRQ enable, one bit per source
//   ipr[31:0]        priority fields: ipr[4i+2:4i] for source i (0 masks it, 7 is highest)
//   tmo[31:0]        timeout count; a request times out when it reads zero
//   tmo_en           timeout counting active
//   cpu_ack          one-cycle CPU acceptance of the pending request
//   cpu_eoi          one-cycle CPU end-of-interrupt
//   irq_req          request to CPU
//   irq_id/irq_prio  source index and priority being requested or serviced
//   I_flag           request outstanding and not yet acknowledged
//   tmo_evt          one-cycle pulse after a request timed out
//   in_service       CPU is servicing irq_id
//   dbg_state        current FSM state (IDLE=0, ARB=1, REQ=2, SERVE=3)
//
// Handshake: irq_req acts as "valid" and cpu_ack acts as "ready". The request
// stays up, with irq_id/irq_prio stable, until one of three events ends it:
// it is accepted in a cycle where irq_req && cpu_ack, it times out, or its
// source stops being eligible. cpu_ack is ignored whenever irq_req is low.
// cpu_eoi is ignored whenever in_service is low.
module plic_arbiter (
  input  logic        pclk,
  input  logic        preset_n,
  input  logic [7:0]  isr,
  input  logic [7:0]  ier,
  input  logic [31:0] ipr,
  input  logic [31:0] tmo,
  input  logic        tmo_en,
  input  logic        cpu_ack,
  input  logic        cpu_eoi,
  output logic        irq_req,
  output logic [2:0]  irq_id,
  output logic [2:0]  irq_prio,
  output logic        I_flag,
  output logic        tmo_evt,
  output logic        in_service,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARB   = 2'd1;
  localparam logic [1:0] ST_REQ   = 2'd2;
  localparam logic [1:0] ST_SERVE = 2'd3;

  logic [1:0] state_q, state_d;
  logic [2:0] irq_id_q, irq_id_d;
  logic [2:0] irq_prio_q, irq_prio_d;
  logic       tmo_evt_q, tmo_evt_d;

  logic [7:0] eligible;
  logic       any_eligible;
  logic [2:0] best_id;
  logic [2:0] best_prio;

  // Bit 3 of every priority nibble carries no meaning.
  logic unused_ipr;
  assign unused_ipr = ^(ipr & 32'h8888_8888);

  // Eligibility and winner search. The strict '>' keeps the earlier, lower
  // index on equal priority. Any eligible source has a priority of at least 1,
  // so a start value of 0 always loses to it.
  always_comb begin
    eligible  = '0;
    best_id   = '0;
    best_prio = '0;
    for (int i = 0; i < 8; i++) begin
      eligible[i] = isr[i] & ier[i] & (|ipr[4*i +: 3]);
      if (eligible[i] && (ipr[4*i +: 3] > best_prio)) begin
        best_prio = ipr[4*i +: 3];
        best_id   = 3'(i);
      end
    end
    any_eligible = |eligible;
  end

  always_comb begin
    state_d    = state_q;
    irq_id_d   = irq_id_q;
    irq_prio_d = irq_prio_q;
    tmo_evt_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_eligible) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (any_eligible) begin
          irq_id_d   = best_id;
          irq_prio_d = best_prio;
          state_d    = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Acceptance wins over timeout, and timeout wins over withdrawal.
        if (cpu_ack) begin
          state_d = ST_SERVE;
        end else if (tmo_en && (tmo == 32'd0)) begin
          tmo_evt_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (!eligible[irq_id_q]) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (cpu_eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q    <= ST_IDLE;
      irq_id_q   <= '0;
      irq_prio_q <= '0;
      tmo_evt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_id_q   <= irq_id_d;
      irq_prio_q <= irq_prio_d;
      tmo_evt_q  <= tmo_evt_d;
    end
  end

  // Every output comes straight from a flop or a decode of state_q, so no
  // input can reach an output combinationally.
  assign irq_req    = (state_q == ST_REQ);
  assign I_flag     = (state_q == ST_REQ);
  assign in_service = (state_q == ST_SERVE);
  assign irq_id     = irq_id_q;
  assign irq_prio   = irq_prio_q;
  assign tmo_evt    = tmo_evt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_plic_arbiter.sv
// Testbench for plic_arbiter. A table of arbitration vectors is followed by
// hand-written sequences for timeout, ack/timeout collision, withdrawal,
// non-preemption and reset during service.
module tb_plic_arbiter;

  // ---------------- clock / reset ----------------
  logic        pclk = 1'b0;
  logic        preset_n;
  logic [7:0]  isr, ier;
  logic [31:0] ipr, tmo;
  logic        tmo_en, cpu_ack, cpu_eoi;
  logic        irq_req, I_flag, tmo_evt, in_service;
  logic [2:0]  irq_id, irq_prio;
  logic [1:0]  dbg_state;

  always #5 pclk = ~pclk;

  plic_arbiter dut (
    .pclk(pclk), .preset_n(preset_n), .isr(isr), .ier(ier), .ipr(ipr),
    .tmo(tmo), .tmo_en(tmo_en), .cpu_ack(cpu_ack), .cpu_eoi(cpu_eoi),
    .irq_req(irq_req), .irq_id(irq_id), .irq_prio(irq_prio), .I_flag(I_flag),
    .tmo_evt(tmo_evt), .in_service(in_service), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [5:0] exp_q[$];   // {irq_id, irq_prio}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input string name);
    logic [5:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, got id=%0d prio=%0d", name, irq_id, irq_prio);
    end else begin
      e = exp_q.pop_front();
      check(name, {26'd0, irq_id, irq_prio}, {26'd0, e});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  function automatic logic [31:0] pf(input int src, input int p);
    return (32'(p) & 32'hF) << (4 * src);
  endfunction

  // From IDLE: present one source pattern, expect REQ two edges later.
  task automatic go_req(input logic [7:0] i_isr, input logic [31:0] i_ipr,
                        input logic [2:0] id, input logic [2:0] pr, input string name);
    isr = i_isr;
    ier = 8'hFF;
    ipr = i_ipr;
    exp_q.push_back({id, pr});
    tick();
    check({name, " arb_no_req"}, 32'(irq_req), 32'd0);
    tick();
    check({name, " irq_req"}, 32'(irq_req), 32'd1);
    check({name, " I_flag"}, 32'(I_flag), 32'd1);
    sb_pop({name, " id_prio"});
  endtask

  // From REQ: accept, drop the source, end the interrupt, and settle in IDLE.
  task automatic clean_up();
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    isr = 8'h00;
    cpu_eoi = 1'b1;
    tick();
    cpu_eoi = 1'b0;
    tmo_en = 1'b0;
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  isr;
    logic [7:0]  ier;
    logic [31:0] ipr;
    logic        exp_req;
    logic [2:0]  exp_id;
    logic [2:0]  exp_prio;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h04, 8'hFF, pf(2, 5), 1'b1, 3'd2, 3'd5};
    vecs[1] = '{8'h82, 8'hFF, pf(1, 3) | pf(7, 3), 1'b1, 3'd1, 3'd3};
    vecs[2] = '{8'h82, 8'hFF, pf(1, 3) | pf(7, 6), 1'b1, 3'd7, 3'd6};
    vecs[3] = '{8'hFF, 8'h3C, 32'h7654_3210, 1'b1, 3'd5, 3'd5};
    vecs[4] = '{8'h04, 8'hFF, pf(2, 15), 1'b1, 3'd2, 3'd7};    // nibble bit 3 ignored
    vecs[5] = '{8'h04, 8'hFF, pf(2, 8), 1'b0, 3'd0, 3'd0};     // field is 0 -> masked
    vecs[6] = '{8'h01, 8'hFF, 32'h0000_0000, 1'b0, 3'd0, 3'd0}; // priority 0
    vecs[7] = '{8'h04, 8'hFB, pf(2, 5), 1'b0, 3'd0, 3'd0};     // not enabled

    isr = '0; ier = '0; ipr = '0; tmo = '0;
    tmo_en = 1'b0; cpu_ack = 1'b0; cpu_eoi = 1'b0;
    preset_n = 1'b0;

    // Reset state, and the latency of the first arbitration after release.
    tick();
    tick();
    check("reset irq_req", 32'(irq_req), 32'd0);
    check("reset outputs", {25'd0, irq_id, irq_prio, tmo_evt}, 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);
    isr = 8'h04; ier = 8'hFF; ipr = pf(2, 5);
    preset_n = 1'b1;
    exp_q.push_back({3'd2, 3'd5});
    tick();
    check("post_reset edge1 no req", 32'(irq_req), 32'd0);
    tick();
    check("post_reset edge2 req", 32'(irq_req), 32'd1);
    sb_pop("post_reset id_prio");
    clean_up();

    // Table-driven arbitration.
    for (int v = 0; v < 8; v++) begin
      isr = vecs[v].isr;
      ier = vecs[v].ier;
      ipr = vecs[v].ipr;
      if (vecs[v].exp_req) exp_q.push_back({vecs[v].exp_id, vecs[v].exp_prio});
      tick();
      check($sformatf("vec%0d arb_no_req", v), 32'(irq_req), 32'd0);
      tick();
      check($sformatf("vec%0d irq_req", v), 32'(irq_req), 32'(vecs[v].exp_req));
      check($sformatf("vec%0d I_flag", v), 32'(I_flag), 32'(vecs[v].exp_req));
      if (vecs[v].exp_req) begin
        sb_pop($sformatf("vec%0d id_prio", v));
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
        check($sformatf("vec%0d serve", v), {29'd0, in_service, irq_req, I_flag}, 32'b100);
        isr = 8'h00;
        cpu_eoi = 1'b1;
        tick();
        cpu_eoi = 1'b0;
        check($sformatf("vec%0d eoi", v), 32'(in_service), 32'd0);
      end else begin
        tick();
        tick();
        check($sformatf("vec%0d stays_idle", v), 32'(irq_req), 32'd0);
        isr = 8'h00;
      end
      tick();
    end

    // Timeout: tmo counts down with no ack.
    go_req(8'h04, pf(2, 5), 3'd2, 3'd5, "tmo");
    tmo_en = 1'b1;
    tmo = 32'd2;
    tick();
    check("tmo cnt2", {30'd0, irq_req, tmo_evt}, 32'b10);
    tmo = 32'd1;
    tick();
    check("tmo cnt1", {30'd0, irq_req, tmo_evt}, 32'b10);
    tmo = 32'd0;
    tick();
    check("tmo evt", {29'd0, tmo_evt, irq_req, I_flag}, 32'b100);
    tmo_en = 1'b0;
    tmo = 32'd9;
    exp_q.push_back({3'd2, 3'd5});
    tick();
    check("tmo evt one_cycle", {30'd0, tmo_evt, irq_req}, 32'b00);
    tick();
    check("tmo rerequest", 32'(irq_req), 32'd1);
    sb_pop("tmo rerequest id_prio");
    clean_up();

    // Ack in the same cycle as timeout; ack in SERVE ignored; re-request after EOI.
    go_req(8'h04, pf(2, 5), 3'd2, 3'd5, "ack_tmo");
    tmo_en = 1'b1;
    tmo = 32'd0;
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    tmo_en = 1'b0;
    check("ack_tmo serve", {29'd0, in_service, tmo_evt, irq_req}, 32'b100);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    check("ack in serve ignored", 32'(in_service), 32'd1);
    cpu_eoi = 1'b1;
    tick();
    cpu_eoi = 1'b0;
    check("eoi in_service low", {30'd0, in_service, irq_req}, 32'b00);
    exp_q.push_back({3'd2, 3'd5});
    tick();
    check("eoi rerequest arb", 32'(irq_req), 32'd0);
    tick();
    check("eoi rerequest", 32'(irq_req), 32'd1);
    sb_pop("eoi rerequest id_prio");
    clean_up();

    // Withdrawal: disable the requesting source while in REQ.
    go_req(8'h04, pf(2, 5), 3'd2, 3'd5, "wd");
    tmo_en = 1'b1;
    tmo = 32'd5;
    ier = 8'hFB;
    tick();
    check("wd drop", {30'd0, irq_req, tmo_evt}, 32'b00);
    tick();
    check("wd idle", {29'd0, tmo_evt, dbg_state}, 32'd0);
    tmo_en = 1'b0;
    isr = 8'h00;
    ier = 8'hFF;
    tick();

    // No preemption, and EOI in REQ ignored.
    go_req(8'h04, pf(2, 3), 3'd2, 3'd3, "np");
    isr = 8'h84;
    ipr = pf(2, 3) | pf(7, 7);
    cpu_eoi = 1'b1;
    tick();
    cpu_eoi = 1'b0;
    check("np eoi ignored", {26'd0, irq_req, irq_id, in_service, I_flag}, {26'd0, 1'b1, 3'd2, 1'b0, 1'b1});
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    check("np serve holds", {25'd0, in_service, irq_id, irq_prio}, {25'd0, 1'b1, 3'd2, 3'd3});
    tick();
    check("np serve holds2", {26'd0, irq_id, irq_prio}, {26'd0, 3'd2, 3'd3});
    isr = 8'h80;
    cpu_eoi = 1'b1;
    tick();
    cpu_eoi = 1'b0;
    exp_q.push_back({3'd7, 3'd7});
    tick();
    tick();
    check("np next req", 32'(irq_req), 32'd1);
    sb_pop("np next id_prio");
    clean_up();

    // Reset pulsed during SERVE, with the source still pending.
    go_req(8'h04, pf(2, 5), 3'd2, 3'd5, "rst");
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    check("rst in serve", 32'(in_service), 32'd1);
    #2;
    preset_n = 1'b0;
    #1;
    check("rst async outputs",
          {23'd0, irq_req, I_flag, tmo_evt, in_service, irq_id, irq_prio}, 32'd0);
    check("rst async state", 32'(dbg_state), 32'd0);
    tick();
    preset_n = 1'b1;
    exp_q.push_back({3'd2, 3'd5});
    tick();
    check("rst release edge1", 32'(irq_req), 32'd0);
    tick();
    check("rst release edge2", 32'(irq_req), 32'd1);
    sb_pop("rst release id_prio");
    clean_up();

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
